layer2_psum_accum: RTL and testbench



---
 rtl/layer2_psum_accum_if.sv | 37 +++
 rtl/layer2_psum_accum.sv | 151 +++++++++++++++
 tb/tb_layer2_psum_accum.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer2_psum_accum_if.sv
// Stream bundle between the layer-2 MAC array, the partial-sum accumulator
// and the downstream pixel consumer.
// Both streams use valid/ready.
// - A transfer happens on a rising clk edge where valid && ready.
// - A producer holds its payload stable while valid && !ready.
// - ready may depend combinationally on the other side's valid/ready.
interface layer2_psum_accum_if;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  psum1;
  logic [15:0]  psum2;
  logic [15:0]  psum3;
  logic [15:0]  psum4;
  logic [15:0]  psum5;
  logic [15:0]  psum6;
  logic [15:0]  psum7;
  logic [15:0]  psum8;
  logic [127:0] bias_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         frame_done;

  // Producer of beats and consumer of finished pixels
  modport master (
    output in_valid, psum1, psum2, psum3, psum4, psum5, psum6, psum7, psum8,
           bias_data, out_ready,
    input  in_ready, out_valid, out_data, frame_done
  );

  // The accumulator itself
  modport slave (
    input  in_valid, psum1, psum2, psum3, psum4, psum5, psum6, psum7, psum8,
           bias_data, out_ready,
    output in_ready, out_valid, out_data, frame_done
  );
endinterface

// File: rtl/layer2_psum_accum.sv
// layer2_psum_accum: sums KERNEL_BEATS beats of eight signed 16-bit partial
// sums per output pixel, starting from a per-channel bias. The sum is
// saturated to 16 bits and presented as one 128-bit word on a valid/ready
// output register. frame_done pulses on the last pixel of a frame.
// Optional build macro LAYER2_RELU_EN: clamps negative channel results to 0.
// The debug outputs expose the beat and pixel counters.
module layer2_psum_accum #(
  parameter int KERNEL_BEATS = 9,
  parameter int ACC_W        = 20,
  parameter int NUM_PIXELS   = 1024,
  localparam int BW = $clog2(KERNEL_BEATS),
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  layer2_psum_accum_if.slave   bus,
  output logic [BW-1:0]        dbg_beat_cnt,
  output logic [PW-1:0]        dbg_pix_cnt
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(KERNEL_BEATS - 1);
  localparam logic [PW-1:0] LAST_PIX  = PW'(NUM_PIXELS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [BW-1:0]            beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]            pix_cnt_q, pix_cnt_d;
  logic signed [ACC_W-1:0]  acc_q [8];
  logic signed [ACC_W-1:0]  acc_d [8];
  logic                     out_valid_q, out_valid_d;
  logic [127:0]             out_data_q, out_data_d;
  logic                     frame_done_q, frame_done_d;

  logic signed [15:0]       psum_w [8];
  logic signed [15:0]       bias_w [8];
  logic signed [ACC_W-1:0]  base_w [8];
  logic signed [ACC_W-1:0]  sum_w  [8];
  logic [15:0]              sat_w  [8];
  logic [15:0]              res_w  [8];
  logic                     last_beat;
  logic                     beat_fire;

  // Gather channel operands; channel 1 sits in the top slice of the bias word
  always_comb begin
    psum_w[0] = bus.psum1;
    psum_w[1] = bus.psum2;
    psum_w[2] = bus.psum3;
    psum_w[3] = bus.psum4;
    psum_w[4] = bus.psum5;
    psum_w[5] = bus.psum6;
    psum_w[6] = bus.psum7;
    psum_w[7] = bus.psum8;
    for (int k = 0; k < 8; k++) begin
      bias_w[k] = bus.bias_data[127-16*k -: 16];
    end
  end

  // Per-channel sum for this beat, then saturation and optional ReLU
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      base_w[k] = (beat_cnt_q == '0) ?
                  {{(ACC_W-16){bias_w[k][15]}}, bias_w[k]} : acc_q[k];
      sum_w[k]  = base_w[k] + {{(ACC_W-16){psum_w[k][15]}}, psum_w[k]};
      if (sum_w[k] > SAT_MAX) begin
        sat_w[k] = 16'h7fff;
      end else if (sum_w[k] < SAT_MIN) begin
        sat_w[k] = 16'h8000;
      end else begin
        sat_w[k] = sum_w[k][15:0];
      end
`ifdef LAYER2_RELU_EN
      res_w[k] = sat_w[k][15] ? 16'h0000 : sat_w[k];
`else
      res_w[k] = sat_w[k];
`endif
    end
  end

  // Only the final beat stalls, and only when the output register is full and not draining
  always_comb begin
    last_beat    = (beat_cnt_q == LAST_BEAT);
    bus.in_ready = !(last_beat && out_valid_q && !bus.out_ready);
    beat_fire    = bus.in_valid && bus.in_ready;
  end

  // Next state: counters, accumulators and the output register
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      // Abort the pixel in progress; a held result is left to drain
      beat_cnt_d = '0;
      pix_cnt_d  = '0;
    end else if (beat_fire) begin
      if (last_beat) begin
        beat_cnt_d  = '0;
        out_valid_d = 1'b1;
        for (int k = 0; k < 8; k++) begin
          out_data_d[127-16*k -: 16] = res_w[k];
        end
        if (pix_cnt_q == LAST_PIX) begin
          pix_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        acc_d      = sum_w;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      acc_q        <= acc_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;
  assign dbg_beat_cnt   = beat_cnt_q;
  assign dbg_pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_layer2_psum_accum.sv
// Testbench for layer2_psum_accum with NUM_PIXELS=4, using directed pixels
// with hand-computed results. Expected words are queued as each pixel is
// issued. A negedge monitor pops and compares on each output transfer.
module tb_layer2_psum_accum;
  localparam int KB = 9;
  localparam int NP = 4;
  localparam int BW = $clog2(KB);
  localparam int PW = $clog2(NP);
  localparam logic [127:0] JUNK = {8{16'h5a5a}};

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic [BW-1:0] dbg_beat_cnt;
  logic [PW-1:0] dbg_pix_cnt;

  layer2_psum_accum_if bus();

  layer2_psum_accum #(.KERNEL_BEATS(KB), .ACC_W(20), .NUM_PIXELS(NP)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .bus          (bus),
    .dbg_beat_cnt (dbg_beat_cnt),
    .dbg_pix_cnt  (dbg_pix_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  logic [127:0] exp_q[$];
  int acc_total = 0;
  int fd_cnt = 0;
  int fd_at = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one comparison per output transfer
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got %h expected none", bus.out_data);
      end else begin
        chk("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  // Accepted-beat counter and frame_done tracker
  always @(posedge clk) begin
    if (rst && !clear && bus.in_valid && bus.in_ready) acc_total++;
  end
  always @(negedge clk) begin
    if (bus.frame_done) begin
      fd_cnt++;
      fd_at = acc_total;
    end
  end

  // Drivers
  task automatic set_ps(input logic [127:0] ps, input logic [127:0] bias);
    bus.psum1 = ps[127:112];
    bus.psum2 = ps[111:96];
    bus.psum3 = ps[95:80];
    bus.psum4 = ps[79:64];
    bus.psum5 = ps[63:48];
    bus.psum6 = ps[47:32];
    bus.psum7 = ps[31:16];
    bus.psum8 = ps[15:0];
    bus.bias_data = bias;
  endtask

  task automatic send_beat(input logic [127:0] ps, input logic [127:0] bias);
    int n;
    set_ps(ps, bias);
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: in_ready stayed 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    set_ps(JUNK, JUNK);
  endtask

  task automatic send_pixel(input logic [127:0] ps, input logic [127:0] bias, input bit gap);
    for (int i = 0; i < KB; i++) begin
      send_beat(ps, (i == 0) ? bias : JUNK);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  logic [127:0] exp_c3;
  logic [127:0] exp_mix;
  int fd_base;
  int acc_base;

  initial begin
`ifdef LAYER2_RELU_EN
    exp_c3  = {16'h0000, 16'h7fff, 16'h0000, 80'h0};
    exp_mix = {16'h000a, 16'h0000, 16'h0000, 16'h0000,
               16'h7fff, 16'h7fff, 16'h0000, 16'h0000};
`else
    exp_c3  = {16'h0000, 16'h7fff, 16'h8000, 80'h0};
    exp_mix = {16'h000a, 16'hfff6, 16'hfffe, 16'h8000,
               16'h7fff, 16'h7fff, 16'h8000, 16'hfffc};
`endif
    rst = 1'b0;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_ps(JUNK, JUNK);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {127'h0, bus.out_valid}, 128'h0);
    chk("rst_out_data", bus.out_data, 128'h0);
    chk("rst_in_ready", {127'h0, bus.in_ready}, 128'h1);
    chk("rst_frame_done", {127'h0, bus.frame_done}, 128'h0);
    @(posedge clk);
    #1;

    // Basic sum: 0x0100 + 9*0x0400
    exp_q.push_back({16'h2500, 112'h0});
    send_pixel({16'h0400, 112'h0}, {16'h0100, 112'h0}, 1'b0);
    drain();

    // Saturation high on ch2, low on ch3
    exp_q.push_back(exp_c3);
    send_pixel({16'h0000, 16'h7000, 16'h9000, 80'h0}, 128'h0, 1'b0);
    drain();

    // Mixed bias/psum per channel, bias must only be taken on the first beat
    exp_q.push_back(exp_mix);
    send_pixel({16'h0001, 16'hffff, 16'hfffe, 16'hffff,
                16'h0001, 16'h1000, 16'hf000, 16'hffff},
               {16'h0001, 16'hffff, 16'h0010, 16'h8000,
                16'h7fff, 16'h0000, 16'h0000, 16'h0005}, 1'b0);
    drain();

    // Gaps between beats give the same result as a contiguous feed
    exp_q.push_back({16'h2500, 112'h0});
    send_pixel({16'h0400, 112'h0}, {16'h0100, 112'h0}, 1'b1);
    drain();

    // Backpressure: A held, B's first 8 beats accepted, 9th stalls
    bus.out_ready = 1'b0;
    exp_q.push_back({16'h0009, 112'h0});
    send_pixel({16'h0001, 112'h0}, 128'h0, 1'b0);
    for (int i = 0; i < KB - 1; i++) begin
      send_beat({16'h0002, 112'h0}, (i == 0) ? 128'h0 : JUNK);
    end
    set_ps({16'h0002, 112'h0}, JUNK);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", {127'h0, bus.in_ready}, 128'h0);
    chk("bp_out_valid", {127'h0, bus.out_valid}, 128'h1);
    chk("bp_hold_a", bus.out_data, {16'h0009, 112'h0});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_hold_a2", bus.out_data, {16'h0009, 112'h0});
    chk("bp_beat_cnt", {{(128-BW){1'b0}}, dbg_beat_cnt}, 128'd8);
    exp_q.push_back({16'h0012, 112'h0});
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_beat({16'h0002, 112'h0}, JUNK);
    @(negedge clk);
    chk("bp_out_valid_b", {127'h0, bus.out_valid}, 128'h1);
    drain();

    // Frame: clear zeroes pix_cnt, then 4 pixels give exactly one frame_done
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clr_pix_cnt", {{(128-PW){1'b0}}, dbg_pix_cnt}, 128'h0);
    @(posedge clk);
    #1;
    fd_base = fd_cnt;
    acc_base = acc_total;
    exp_q.push_back({48'h0, 16'd9, 64'h0});
    exp_q.push_back({48'h0, 16'd18, 64'h0});
    exp_q.push_back({48'h0, 16'd27, 64'h0});
    exp_q.push_back({48'h0, 16'd36, 64'h0});
    for (int p = 1; p <= 4; p++) begin
      send_pixel({48'h0, 16'(p), 64'h0}, 128'h0, 1'b0);
      if (p == 3) begin
        @(negedge clk);
        chk("frame_pix_cnt3", {{(128-PW){1'b0}}, dbg_pix_cnt}, 128'd3);
        chk("frame_no_fd_yet", 128'(fd_cnt - fd_base), 128'd0);
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("frame_fd_count", 128'(fd_cnt - fd_base), 128'd1);
    chk("frame_fd_beat", 128'(fd_at - acc_base), 128'd36);
    chk("frame_pix_wrap", {{(128-PW){1'b0}}, dbg_pix_cnt}, 128'h0);

    // Reset mid-pixel with a pending result: everything returns to reset values
    bus.out_ready = 1'b0;
    send_pixel({16'h0003, 112'h0}, 128'h0, 1'b0);
    for (int i = 0; i < 5; i++) send_beat({16'h0400, 112'h0}, {16'h0100, 112'h0});
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", {127'h0, bus.out_valid}, 128'h0);
    chk("mrst_out_data", bus.out_data, 128'h0);
    chk("mrst_in_ready", {127'h0, bus.in_ready}, 128'h1);
    chk("mrst_frame_done", {127'h0, bus.frame_done}, 128'h0);
    chk("mrst_beat_cnt", {{(128-BW){1'b0}}, dbg_beat_cnt}, 128'h0);
    chk("mrst_pix_cnt", {{(128-PW){1'b0}}, dbg_pix_cnt}, 128'h0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    exp_q.push_back({64'h0, 16'h001c, 48'h0});
    send_pixel({64'h0, 16'h0003, 48'h0}, {64'h0, 16'h0001, 48'h0}, 1'b0);
    drain();

    // Clear mid-pixel with a pending result: result kept, partial pixel dropped
    bus.out_ready = 1'b0;
    exp_q.push_back({80'h0, 16'h0012, 32'h0});
    send_pixel({80'h0, 16'h0002, 32'h0}, 128'h0, 1'b0);
    for (int i = 0; i < 5; i++) send_beat({16'h0400, 112'h0}, {16'h0100, 112'h0});
    set_ps({8{16'h7000}}, {8{16'h7000}});
    bus.in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", {127'h0, bus.out_valid}, 128'h1);
    chk("clr_out_data", bus.out_data, {80'h0, 16'h0012, 32'h0});
    chk("clr_beat_cnt", {{(128-BW){1'b0}}, dbg_beat_cnt}, 128'h0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    exp_q.push_back({96'h0, 16'h0019, 16'h0});
    send_pixel({96'h0, 16'h0001, 16'h0}, {96'h0, 16'h0010, 16'h0}, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
